// File: rtl/ga23_pkg.sv
// Shared definitions for the GA23 palette mixer: index width, transparency
// test, CPU access FSM states and RGB555 field offsets.
package ga23_pkg;

    localparam int PAL_AW        = 11;
    localparam int TRANSP_NIBBLE = 4;

    localparam int RED_LSB   = 0;
    localparam int GREEN_LSB = 5;
    localparam int BLUE_LSB  = 10;
    localparam int CH_W      = 5;

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_WAIT   = 2'd1,
        CPU_ACCESS = 2'd2,
        CPU_DONE   = 2'd3
    } cpu_state_t;

    // A pixel is transparent when its low 'nibble' index bits are all zero.
    function automatic logic is_transparent(input logic [PAL_AW-1:0] color,
                                            input int nibble);
        logic any_set;
        any_set = 1'b0;
        for (int i = 0; i < PAL_AW; i++) begin
            if (i < nibble) any_set = any_set | color[i];
        end
        return ~any_set;
    endfunction

endpackage

// File: rtl/ga23_palette_ram.sv
// Single-port synchronous palette RAM, read-first, one clk read latency.
// Written so synthesis maps it onto a block RAM.
module ga23_palette_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/ga23_palette_mixer.sv
// Tile/sprite priority mixer feeding a shared palette RAM; the CPU borrows the
// RAM through a cs/rd/wr/busy handshake whenever the pixel slot is not using it.
module ga23_palette_mixer
    import ga23_pkg::*;
#(
    parameter int PAL_AW        = ga23_pkg::PAL_AW,
    parameter int TRANSP_NIBBLE = ga23_pkg::TRANSP_NIBBLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [PAL_AW-1:0] tile_color,
    input  logic              tile_prio,
    input  logic [PAL_AW-1:0] obj_color,
    input  logic              obj_prio,
    input  logic              color_blank,
    input  logic              mem_cs,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [PAL_AW:0]   addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              busy,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue
);

    logic [PAL_AW-1:0] mix_idx;
    logic              obj_opaque;
    logic              tile_transp;

    logic [PAL_AW-1:0] idx_d1;
    logic              blank_d1;
    logic              valid_m;
    logic              slot;
    logic              data_cycle;
    logic [14:0]       pix_data;
    logic [14:0]       pix_word;

    cpu_state_t        state;
    logic              prev_req;
    logic              req_term;
    logic              request;
    logic              cpu_we;
    logic [15:0]       cpu_wdata;
    logic [PAL_AW-1:0] cpu_entry;

    logic              ram_en;
    logic              ram_we;
    logic [PAL_AW-1:0] ram_addr;
    logic [15:0]       ram_q;

    logic              unused_addr_lsb;
    assign unused_addr_lsb = addr[0];

    always_comb begin
        obj_opaque  = ~is_transparent(obj_color, TRANSP_NIBBLE);
        tile_transp = is_transparent(tile_color, TRANSP_NIBBLE);
        if (obj_opaque && (obj_prio || !tile_prio || tile_transp))
            mix_idx = obj_color;
        else
            mix_idx = tile_color;
    end

    // The RAM word lands the clk after the slot; if the next ce_pix arrives
    // that same clk take it straight from the RAM, otherwise from the copy.
    assign pix_word = data_cycle ? ram_q[14:0] : pix_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_d1     <= '0;
            blank_d1   <= 1'b0;
            valid_m    <= 1'b0;
            slot       <= 1'b0;
            data_cycle <= 1'b0;
            pix_data   <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            slot       <= ce_pix;
            data_cycle <= slot;
            if (data_cycle) pix_data <= ram_q[14:0];
            if (ce_pix) begin
                idx_d1   <= mix_idx;
                blank_d1 <= color_blank;
                valid_m  <= 1'b1;
                if (!valid_m || blank_d1) begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end else begin
                    red   <= pix_word[RED_LSB   +: CH_W];
                    green <= pix_word[GREEN_LSB +: CH_W];
                    blue  <= pix_word[BLUE_LSB  +: CH_W];
                end
            end
        end
    end

    assign busy     = (state != CPU_IDLE);
    assign req_term = mem_cs & (mem_rd | mem_wr);
    assign request  = req_term & ~busy & ~prev_req;

    // Leaving WAIT only on a clk without ce_pix guarantees the ACCESS clk is
    // never a pixel slot, so the pixel read always owns the RAM on its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CPU_IDLE;
            prev_req  <= 1'b0;
            cpu_dout  <= '0;
            cpu_we    <= 1'b0;
            cpu_wdata <= '0;
            cpu_entry <= '0;
        end else begin
            prev_req <= req_term;
            case (state)
                CPU_IDLE: begin
                    if (request) begin
                        state     <= CPU_WAIT;
                        cpu_we    <= mem_wr;
                        cpu_wdata <= cpu_din;
                        cpu_entry <= addr[PAL_AW:1];
                    end
                end
                CPU_WAIT: begin
                    if (!ce_pix) state <= CPU_ACCESS;
                end
                CPU_ACCESS: state <= CPU_DONE;
                CPU_DONE: begin
                    if (!cpu_we) cpu_dout <= ram_q;
                    state <= CPU_IDLE;
                end
                default: state <= CPU_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = idx_d1;
        if (slot) begin
            ram_en = 1'b1;
        end else if (state == CPU_ACCESS) begin
            ram_en   = 1'b1;
            ram_we   = cpu_we;
            ram_addr = cpu_entry;
        end
    end

    ga23_palette_ram #(
        .AW (PAL_AW),
        .DW (16)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (cpu_wdata),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_ga23_palette_mixer.sv
// Directed bench for ga23_palette_mixer: priority mixing, latency, blanking,
// CPU access arbitration, edge-triggered strobes and reset mid-access.
module tb_ga23_palette_mixer;

    logic        clk;
    logic        reset;
    logic        ce_pix;
    logic [10:0] tile_color;
    logic        tile_prio;
    logic [10:0] obj_color;
    logic        obj_prio;
    logic        color_blank;
    logic        mem_cs;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        busy;
    logic [4:0]  red;
    logic [4:0]  green;
    logic [4:0]  blue;

    int tests_run;
    int tests_failed;

    ga23_palette_mixer dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .tile_color  (tile_color),
        .tile_prio   (tile_prio),
        .obj_color   (obj_color),
        .obj_prio    (obj_prio),
        .color_blank (color_blank),
        .mem_cs      (mem_cs),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .addr        (addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .busy        (busy),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Palette contents loaded by the bench, as packed {blue,green,red}.
    function automatic logic [14:0] exp_rgb(input logic [10:0] idx);
        case (idx)
            11'h123: return 15'h0421;
            11'h456: return 15'h2C62;
            11'h120: return 15'h0008;
            11'h450: return 15'h7FFF;
            11'h7FF: return 15'h7C1F;
            default: return 15'h0000;
        endcase
    endfunction

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 20) begin
            clk_step();
            n++;
        end
        if (busy) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL busy_timeout got busy=1 expected busy=0 within 20 clk");
        end
        clk_step();
    endtask

    task automatic cpu_write(input logic [10:0] entry, input logic [15:0] data);
        addr    = {entry, 1'b0};
        cpu_din = data;
        mem_cs  = 1'b1;
        mem_wr  = 1'b1;
        clk_step();
        mem_cs  = 1'b0;
        mem_wr  = 1'b0;
        wait_idle();
    endtask

    task automatic cpu_read(input logic [10:0] entry, output logic [15:0] data);
        addr   = {entry, 1'b0};
        mem_cs = 1'b1;
        mem_rd = 1'b1;
        clk_step();
        mem_cs = 1'b0;
        mem_rd = 1'b0;
        wait_idle();
        data = cpu_dout;
    endtask

    task automatic send_pixel(input logic [10:0] tc, input logic tp,
                              input logic [10:0] oc, input logic op,
                              input logic blank);
        tile_color  = tc;
        tile_prio   = tp;
        obj_color   = oc;
        obj_prio    = op;
        color_blank = blank;
        ce_pix      = 1'b1;
        clk_step();
        ce_pix      = 1'b0;
        clk_step();
        clk_step();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) clk_step();
        tests_run++;
        if ({blue, green, red} !== 15'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rgb got %h expected 0000", {blue, green, red});
        end
        tests_run++;
        if (cpu_dout !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_cpu_dout got %h expected 0000", cpu_dout);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy got %b expected 0", busy);
        end
        reset = 1'b0;
        clk_step();
    endtask

    task automatic test_cpu_rw;
        logic [15:0] rd;
        int cnt;
        cpu_write(11'h123, 16'h0421);
        cpu_write(11'h456, 16'h2C62);
        cpu_write(11'h120, 16'h0008);
        cpu_write(11'h450, 16'h7FFF);
        addr    = {11'h7FF, 1'b0};
        cpu_din = 16'h7C1F;
        mem_cs  = 1'b1;
        mem_wr  = 1'b1;
        clk_step();
        mem_cs  = 1'b0;
        mem_wr  = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            clk_step();
        end
        tests_run++;
        if (cnt != 3) begin
            tests_failed++;
            $display("[TB] FAIL idle_busy_len got %0d expected 3", cnt);
        end
        clk_step();
        cpu_read(11'h7FF, rd);
        tests_run++;
        if (rd !== 16'h7C1F) begin
            tests_failed++;
            $display("[TB] FAIL readback_7ff got %h expected 7c1f", rd);
        end
        addr    = {11'h300, 1'b0};
        cpu_din = 16'h0ABC;
        mem_cs  = 1'b1;
        mem_rd  = 1'b1;
        mem_wr  = 1'b1;
        clk_step();
        mem_cs  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        wait_idle();
        cpu_read(11'h300, rd);
        tests_run++;
        if (rd !== 16'h0ABC) begin
            tests_failed++;
            $display("[TB] FAIL rd_wr_both got %h expected 0abc", rd);
        end
        cpu_write(11'h020, 16'h0AAA);
    endtask

    task automatic test_pixel_select;
        logic [10:0] tc [6];
        logic        tp [6];
        logic [10:0] oc [6];
        logic        op [6];
        logic [10:0] ex [6];
        tc = '{11'h123, 11'h123, 11'h123, 11'h123, 11'h120, 11'h120};
        tp = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        oc = '{11'h456, 11'h456, 11'h456, 11'h450, 11'h450, 11'h456};
        op = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        ex = '{11'h123, 11'h456, 11'h456, 11'h123, 11'h120, 11'h456};
        for (int k = 0; k < 6; k++) begin
            send_pixel(tc[k], tp[k], oc[k], op[k], 1'b0);
            tests_run++;
            if (k == 0) begin
                if ({blue, green, red} !== 15'h0) begin
                    tests_failed++;
                    $display("[TB] FAIL first_pixel_after_reset got %h expected 0000",
                             {blue, green, red});
                end
            end else if ({blue, green, red} !== exp_rgb(ex[k-1])) begin
                tests_failed++;
                $display("[TB] FAIL select_%0d got %h expected %h", k - 1,
                         {blue, green, red}, exp_rgb(ex[k-1]));
            end
        end
    endtask

    task automatic test_write_then_pixel;
        logic [15:0] rd;
        send_pixel(11'h7FF, 1'b1, 11'h450, 1'b0, 1'b0);
        tests_run++;
        if ({blue, green, red} !== 15'h2C62) begin
            tests_failed++;
            $display("[TB] FAIL select_5 got %h expected 2c62", {blue, green, red});
        end
        repeat (5) clk_step();
        tests_run++;
        if ({blue, green, red} !== 15'h2C62) begin
            tests_failed++;
            $display("[TB] FAIL output_hold got %h expected 2c62", {blue, green, red});
        end
        send_pixel(11'h123, 1'b1, 11'h450, 1'b0, 1'b0);
        tests_run++;
        if (red !== 5'd31 || green !== 5'd0 || blue !== 5'd31) begin
            tests_failed++;
            $display("[TB] FAIL pixel_7ff got r=%0d g=%0d b=%0d expected r=31 g=0 b=31",
                     red, green, blue);
        end
        cpu_read(11'h7FF, rd);
        tests_run++;
        if (rd !== 16'h7C1F) begin
            tests_failed++;
            $display("[TB] FAIL readback_after_pixel got %h expected 7c1f", rd);
        end
    endtask

    task automatic test_blank;
        send_pixel(11'h456, 1'b1, 11'h450, 1'b0, 1'b1);
        tests_run++;
        if ({blue, green, red} !== 15'h0421) begin
            tests_failed++;
            $display("[TB] FAIL pre_blank got %h expected 0421", {blue, green, red});
        end
        send_pixel(11'h123, 1'b1, 11'h450, 1'b0, 1'b0);
        tests_run++;
        if ({blue, green, red} !== 15'h0) begin
            tests_failed++;
            $display("[TB] FAIL blanked got %h expected 0000", {blue, green, red});
        end
        send_pixel(11'h123, 1'b1, 11'h450, 1'b0, 1'b0);
        tests_run++;
        if ({blue, green, red} !== 15'h0421) begin
            tests_failed++;
            $display("[TB] FAIL unblank got %h expected 0421", {blue, green, red});
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] seq [7];
        logic [14:0] ex;
        logic [15:0] rd;
        int busy_cnt;
        seq = '{11'h123, 11'h456, 11'h123, 11'h456, 11'h123, 11'h456, 11'h123};
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            ce_pix = (i % 2 == 0);
            if (ce_pix) begin
                tile_color  = seq[i/2];
                tile_prio   = 1'b1;
                obj_color   = 11'h450;
                obj_prio    = 1'b0;
                color_blank = 1'b0;
            end
            if (i == 3) begin
                addr    = {11'h200, 1'b0};
                cpu_din = 16'h1111;
                mem_cs  = 1'b1;
                mem_wr  = 1'b1;
            end else begin
                mem_cs  = 1'b0;
                mem_wr  = 1'b0;
            end
            clk_step();
            if (busy) busy_cnt++;
            if (i % 2 == 0) begin
                ex = (i == 0) ? exp_rgb(11'h123) : exp_rgb(seq[i/2-1]);
                tests_run++;
                if ({blue, green, red} !== ex) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_pixel_%0d got %h expected %h", i / 2,
                             {blue, green, red}, ex);
                end
            end
        end
        ce_pix = 1'b0;
        tests_run++;
        if (busy_cnt < 1 || busy_cnt > 5 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_busy_len got %0d (busy=%b) expected 1..5 and idle",
                     busy_cnt, busy);
        end
        clk_step();
        cpu_read(11'h200, rd);
        tests_run++;
        if (rd !== 16'h1111) begin
            tests_failed++;
            $display("[TB] FAIL b2b_write got %h expected 1111", rd);
        end
    endtask

    task automatic test_held_write;
        logic [15:0] rd;
        logic busy_prev;
        int rises;
        rises     = 0;
        busy_prev = busy;
        addr      = {11'h010, 1'b0};
        mem_cs    = 1'b1;
        mem_wr    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cpu_din = 16'h1000 + 16'(i);
            clk_step();
            if (busy && !busy_prev) rises++;
            busy_prev = busy;
        end
        mem_cs = 1'b0;
        mem_wr = 1'b0;
        wait_idle();
        tests_run++;
        if (rises != 1) begin
            tests_failed++;
            $display("[TB] FAIL held_access_count got %0d expected 1", rises);
        end
        cpu_read(11'h010, rd);
        tests_run++;
        if (rd !== 16'h1000) begin
            tests_failed++;
            $display("[TB] FAIL held_write_data got %h expected 1000", rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        addr    = {11'h020, 1'b0};
        cpu_din = 16'h5555;
        mem_cs  = 1'b1;
        mem_wr  = 1'b1;
        clk_step();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wait_busy got %b expected 1", busy);
        end
        reset  = 1'b1;
        mem_cs = 1'b0;
        mem_wr = 1'b0;
        clk_step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_busy got %b expected 0", busy);
        end
        tests_run++;
        if ({blue, green, red} !== 15'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_rgb got %h expected 0000", {blue, green, red});
        end
        reset = 1'b0;
        clk_step();
        cpu_read(11'h020, rd);
        tests_run++;
        if (rd !== 16'h0AAA) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_entry got %h expected 0aaa", rd);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        ce_pix       = 1'b0;
        tile_color   = '0;
        tile_prio    = 1'b0;
        obj_color    = '0;
        obj_prio     = 1'b0;
        color_blank  = 1'b0;
        mem_cs       = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        addr         = '0;
        cpu_din      = '0;

        test_reset();
        test_cpu_rw();
        test_pixel_select();
        test_write_then_pixel();
        test_blank();
        test_back_to_back();
        test_held_write();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
